// File: rtl/acq_peak_search_if.sv
// Bundles the control inputs, the correlator i2q2 stream and the sweep results
// of acq_peak_search. The master is the sweep controller, the slave is the peak search.
interface acq_peak_search_if #(
  parameter int I2Q2_WIDTH  = 38,
  parameter int SHIFT_WIDTH = 15,
  parameter int SUM_WIDTH   = 53
);
  logic                   start;
  logic [SHIFT_WIDTH-1:0] num_shifts;
  logic [I2Q2_WIDTH-1:0]  threshold;
  logic [I2Q2_WIDTH-1:0]  i2q2;
  logic                   i2q2_valid;
  logic [SHIFT_WIDTH-1:0] code_shift;
  logic                   busy;
  logic                   done;
  logic                   detected;
  logic [I2Q2_WIDTH-1:0]  peak_value;
  logic [SHIFT_WIDTH-1:0] peak_shift;
  logic [I2Q2_WIDTH-1:0]  second_value;
  logic [SUM_WIDTH-1:0]   energy_sum;
  logic [SHIFT_WIDTH-1:0] result_count;

  modport master (
    output start, num_shifts, threshold, i2q2, i2q2_valid, code_shift,
    input  busy, done, detected, peak_value, peak_shift, second_value,
           energy_sum, result_count
  );

  modport slave (
    input  start, num_shifts, threshold, i2q2, i2q2_valid, code_shift,
    output busy, done, detected, peak_value, peak_shift, second_value,
           energy_sum, result_count
  );
endinterface

// File: rtl/acq_peak_search.sv
// Acquisition peak search: tracks the peak, the runner-up and the total energy over one
// sweep of correlator results, then issues a threshold-plus-margin detect decision.
module acq_peak_search #(
  parameter int I2Q2_WIDTH   = 38,
  parameter int SHIFT_WIDTH  = 15,
  parameter int MARGIN_SHIFT = 2,
  parameter int SUM_WIDTH    = 53
) (
  input  logic             clk,
  input  logic             reset,
  acq_peak_search_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_e;

  state_e                 state_q, state_d;
  logic [SHIFT_WIDTH-1:0] num_q, num_d;
  logic [I2Q2_WIDTH-1:0]  thr_q, thr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   detected_q, detected_d;
  logic [I2Q2_WIDTH-1:0]  peak_q, peak_d;
  logic [SHIFT_WIDTH-1:0] peak_shift_q, peak_shift_d;
  logic [I2Q2_WIDTH-1:0]  second_q, second_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [SHIFT_WIDTH-1:0] count_q, count_d;

  logic                   finish;
  logic [SUM_WIDTH:0]     sum_ext;
  logic [I2Q2_WIDTH:0]    margin;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    num_d        = num_q;
    thr_d        = thr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    detected_d   = detected_q;
    peak_d       = peak_q;
    peak_shift_d = peak_shift_q;
    second_d     = second_q;
    sum_d        = sum_q;
    count_d      = count_q;
    finish       = 1'b0;
    sum_ext      = '0;
    margin       = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          num_d        = bus.num_shifts;
          thr_d        = bus.threshold;
          peak_d       = '0;
          peak_shift_d = '0;
          second_d     = '0;
          sum_d        = '0;
          count_d      = '0;
          detected_d   = 1'b0;
          busy_d       = 1'b1;
          state_d      = SEARCH;
        end
      end

      SEARCH: begin
        if (num_q == '0) begin
          finish = 1'b1;
        end else if (bus.i2q2_valid) begin
          count_d = count_q + 1'b1;
          sum_ext = {1'b0, sum_q} + {{(SUM_WIDTH + 1 - I2Q2_WIDTH){1'b0}}, bus.i2q2};
          sum_d   = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
          // Strict compares: an equal value never displaces the peak, but may fill second.
          if (bus.i2q2 > peak_q) begin
            second_d     = peak_q;
            peak_d       = bus.i2q2;
            peak_shift_d = bus.code_shift;
          end else if (bus.i2q2 > second_q) begin
            second_d = bus.i2q2;
          end
          if (count_d == num_q) finish = 1'b1;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // The decision is taken from the post-update values so it is valid alongside done.
    if (finish) begin
      state_d    = FINISH;
      done_d     = 1'b1;
      busy_d     = 1'b0;
      margin     = {1'b0, second_d} + {1'b0, (second_d >> MARGIN_SHIFT)};
      detected_d = (peak_d >= thr_q) && ({1'b0, peak_d} > margin);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
    if (reset) begin
      state_q      <= IDLE;
      num_q        <= '0;
      thr_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      detected_q   <= 1'b0;
      peak_q       <= '0;
      peak_shift_q <= '0;
      second_q     <= '0;
      sum_q        <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      thr_q        <= thr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      detected_q   <= detected_d;
      peak_q       <= peak_d;
      peak_shift_q <= peak_shift_d;
      second_q     <= second_d;
      sum_q        <= sum_d;
      count_q      <= count_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.detected     = detected_q;
  assign bus.peak_value   = peak_q;
  assign bus.peak_shift   = peak_shift_q;
  assign bus.second_value = second_q;
  assign bus.energy_sum   = sum_q;
  assign bus.result_count = count_q;

endmodule

// File: tb/tb_acq_peak_search.sv
// Directed bench for acq_peak_search: hand-computed sweeps, tie and margin cases,
// control corner cases, and saturation on a narrow-accumulator instance.
module tb_acq_peak_search;
  localparam int IW = 38;
  localparam int SW = 15;
  localparam int NARROW_SUM = 40;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   done_ref;

  always #5 clk = ~clk;

  acq_peak_search_if #(.I2Q2_WIDTH(IW), .SHIFT_WIDTH(SW), .SUM_WIDTH(53)) bus ();
  acq_peak_search_if #(.I2Q2_WIDTH(IW), .SHIFT_WIDTH(SW), .SUM_WIDTH(NARROW_SUM)) bus2 ();

  acq_peak_search #(.I2Q2_WIDTH(IW), .SHIFT_WIDTH(SW), .MARGIN_SHIFT(2), .SUM_WIDTH(53))
    dut (.clk(clk), .reset(reset), .bus(bus));

  acq_peak_search #(.I2Q2_WIDTH(IW), .SHIFT_WIDTH(SW), .MARGIN_SHIFT(2), .SUM_WIDTH(NARROW_SUM))
    dut_narrow (.clk(clk), .reset(reset), .bus(bus2));

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [SW-1:0] n, input logic [IW-1:0] thr);
    bus.start = 1'b1; bus.num_shifts = n; bus.threshold = thr;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] v, input logic [SW-1:0] s);
    bus.i2q2_valid = 1'b1; bus.i2q2 = v; bus.code_shift = s;
    tick();
    bus.i2q2_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_vec++; if ({bus.busy, bus.done, bus.detected, bus.peak_value, bus.peak_shift, bus.second_value, bus.energy_sum, bus.result_count} !== '0) begin n_bad++; $display("FAIL reset_outputs: busy=%0b done=%0b det=%0b peak=%0d cnt=%0d, expected all zero", bus.busy, bus.done, bus.detected, bus.peak_value, bus.result_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_detect();
    done_ref = done_cnt;
    start_sweep(15'd4, 38'd100);
    n_vec++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b exp 1", bus.busy); end
    send(38'd10, 15'd0); send(38'd300, 15'd1); send(38'd50, 15'd2); send(38'd20, 15'd3);
    n_vec++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL basic_done_latency: got %0b exp 1", bus.done); end
    n_vec++; if (bus.detected !== 1'b1) begin n_bad++; $display("FAIL basic_detected_at_done: got %0b exp 1", bus.detected); end
    send(38'd1000, 15'd4);  // lands in the done cycle
    send(38'd2000, 15'd5);  // lands in idle
    tick();
    n_vec++; if (bus.peak_value !== 38'd300) begin n_bad++; $display("FAIL basic_peak: got %0d exp 300", bus.peak_value); end
    n_vec++; if (bus.peak_shift !== 15'd1) begin n_bad++; $display("FAIL basic_shift: got %0d exp 1", bus.peak_shift); end
    n_vec++; if (bus.second_value !== 38'd50) begin n_bad++; $display("FAIL basic_second: got %0d exp 50", bus.second_value); end
    n_vec++; if (bus.energy_sum !== 53'd380) begin n_bad++; $display("FAIL basic_sum: got %0d exp 380", bus.energy_sum); end
    n_vec++; if (bus.result_count !== 15'd4) begin n_bad++; $display("FAIL basic_count: got %0d exp 4", bus.result_count); end
    n_vec++; if (bus.detected !== 1'b1) begin n_bad++; $display("FAIL basic_detected_hold: got %0b exp 1", bus.detected); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %0b exp 0", bus.busy); end
    n_vec++; if (done_cnt - done_ref !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d exp 1", done_cnt - done_ref); end
  endtask

  task automatic test_margin_fail();
    start_sweep(15'd3, 38'd100);
    send(38'd200, 15'd0); send(38'd190, 15'd1); send(38'd5, 15'd2);
    n_vec++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL margin_done: got %0b exp 1", bus.done); end
    n_vec++; if (bus.detected !== 1'b0) begin n_bad++; $display("FAIL margin_detected: got %0b exp 0", bus.detected); end
    n_vec++; if (bus.peak_shift !== 15'd0) begin n_bad++; $display("FAIL margin_shift: got %0d exp 0", bus.peak_shift); end
    n_vec++; if (bus.second_value !== 38'd190) begin n_bad++; $display("FAIL margin_second: got %0d exp 190", bus.second_value); end
    n_vec++; if (bus.energy_sum !== 53'd395) begin n_bad++; $display("FAIL margin_sum: got %0d exp 395", bus.energy_sum); end
    tick();
  endtask

  task automatic test_ties();
    start_sweep(15'd3, 38'd50);
    send(38'd80, 15'd5); send(38'd80, 15'd6); send(38'd80, 15'd7);
    n_vec++; if (bus.peak_value !== 38'd80) begin n_bad++; $display("FAIL tie_peak: got %0d exp 80", bus.peak_value); end
    n_vec++; if (bus.peak_shift !== 15'd5) begin n_bad++; $display("FAIL tie_shift: got %0d exp 5", bus.peak_shift); end
    n_vec++; if (bus.second_value !== 38'd80) begin n_bad++; $display("FAIL tie_second: got %0d exp 80", bus.second_value); end
    n_vec++; if (bus.detected !== 1'b0) begin n_bad++; $display("FAIL tie_detected: got %0b exp 0", bus.detected); end
    tick();
  endtask

  task automatic test_threshold();
    start_sweep(15'd2, 38'd100);
    send(38'd90, 15'd0); send(38'd10, 15'd1);
    n_vec++; if (bus.detected !== 1'b0) begin n_bad++; $display("FAIL thr_below_detected: got %0b exp 0", bus.detected); end
    tick();
    // A start coincident with a valid in idle must not count that valid; peak equal to threshold detects.
    bus.start = 1'b1; bus.num_shifts = 15'd2; bus.threshold = 38'd100;
    bus.i2q2_valid = 1'b1; bus.i2q2 = 38'd999; bus.code_shift = 15'd9;
    tick();
    bus.start = 1'b0; bus.i2q2_valid = 1'b0;
    n_vec++; if (bus.result_count !== 15'd0) begin n_bad++; $display("FAIL start_valid_count: got %0d exp 0", bus.result_count); end
    n_vec++; if (bus.peak_value !== 38'd0) begin n_bad++; $display("FAIL start_valid_peak: got %0d exp 0", bus.peak_value); end
    send(38'd100, 15'd3); send(38'd0, 15'd4);
    n_vec++; if (bus.detected !== 1'b1) begin n_bad++; $display("FAIL thr_equal_detected: got %0b exp 1", bus.detected); end
    n_vec++; if (bus.peak_shift !== 15'd3) begin n_bad++; $display("FAIL thr_equal_shift: got %0d exp 3", bus.peak_shift); end
    tick();
  endtask

  task automatic test_zero_shifts();
    start_sweep(15'd0, 38'd0);
    n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL zero_done_early: got %0b exp 0", bus.done); end
    n_vec++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy: got %0b exp 1", bus.busy); end
    tick();
    n_vec++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %0b exp 1", bus.done); end
    n_vec++; if (bus.detected !== 1'b0) begin n_bad++; $display("FAIL zero_detected: got %0b exp 0", bus.detected); end
    n_vec++; if ({bus.peak_value, bus.second_value, bus.result_count} !== '0) begin n_bad++; $display("FAIL zero_values: peak=%0d second=%0d cnt=%0d exp 0", bus.peak_value, bus.second_value, bus.result_count); end
    tick();
    n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL zero_done_width: got %0b exp 0", bus.done); end
  endtask

  task automatic test_start_while_busy();
    start_sweep(15'd6, 38'd10);
    send(38'd5, 15'd0); send(38'd9, 15'd1); send(38'd7, 15'd2);
    bus.start = 1'b1; bus.num_shifts = 15'd1; bus.threshold = 38'd0;
    tick();
    bus.start = 1'b0;
    tick();
    n_vec++; if (bus.result_count !== 15'd3) begin n_bad++; $display("FAIL busy_start_count: got %0d exp 3", bus.result_count); end
    n_vec++; if (bus.peak_value !== 38'd9) begin n_bad++; $display("FAIL busy_start_peak: got %0d exp 9", bus.peak_value); end
    send(38'd1, 15'd3); send(38'd2, 15'd4); send(38'd3, 15'd5);
    n_vec++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL busy_start_done: got %0b exp 1", bus.done); end
    n_vec++; if (bus.result_count !== 15'd6) begin n_bad++; $display("FAIL busy_start_final_count: got %0d exp 6", bus.result_count); end
    n_vec++; if (bus.second_value !== 38'd7) begin n_bad++; $display("FAIL busy_start_second: got %0d exp 7", bus.second_value); end
    n_vec++; if (bus.energy_sum !== 53'd27) begin n_bad++; $display("FAIL busy_start_sum: got %0d exp 27", bus.energy_sum); end
    n_vec++; if (bus.detected !== 1'b0) begin n_bad++; $display("FAIL busy_start_detected: got %0b exp 0", bus.detected); end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    done_ref = done_cnt;
    start_sweep(15'd5, 38'd10);
    send(38'd33, 15'd0); send(38'd44, 15'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if ({bus.busy, bus.done, bus.detected, bus.peak_value, bus.peak_shift, bus.second_value, bus.energy_sum, bus.result_count} !== '0) begin n_bad++; $display("FAIL midreset_outputs: busy=%0b peak=%0d sum=%0d cnt=%0d exp all zero", bus.busy, bus.peak_value, bus.energy_sum, bus.result_count); end
    tick(); tick(); tick();
    n_vec++; if (done_cnt !== done_ref) begin n_bad++; $display("FAIL midreset_no_done: got %0d pulses exp 0", done_cnt - done_ref); end
    start_sweep(15'd2, 38'd50);
    send(38'd40, 15'd0); send(38'd60, 15'd1);
    n_vec++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL midreset_rerun_done: got %0b exp 1", bus.done); end
    n_vec++; if (bus.peak_value !== 38'd60 || bus.second_value !== 38'd40) begin n_bad++; $display("FAIL midreset_rerun_values: peak=%0d second=%0d exp 60/40", bus.peak_value, bus.second_value); end
    n_vec++; if (bus.detected !== 1'b1) begin n_bad++; $display("FAIL midreset_rerun_detected: got %0b exp 1", bus.detected); end
    n_vec++; if (bus.result_count !== 15'd2) begin n_bad++; $display("FAIL midreset_rerun_count: got %0d exp 2", bus.result_count); end
    tick();
  endtask

  task automatic test_saturation();
    bus2.start = 1'b1; bus2.num_shifts = 15'd6; bus2.threshold = '0;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus2.i2q2_valid = 1'b1; bus2.i2q2 = '1; bus2.code_shift = SW'(i);
      tick();
      if (i == 3) begin
        n_vec++; if (bus2.energy_sum !== 40'hFF_FFFF_FFFC) begin n_bad++; $display("FAIL sat_before: got %h exp fffffffffc", bus2.energy_sum); end
      end
    end
    bus2.i2q2_valid = 1'b0;
    n_vec++; if (bus2.done !== 1'b1) begin n_bad++; $display("FAIL sat_done: got %0b exp 1", bus2.done); end
    n_vec++; if (bus2.energy_sum !== 40'hFF_FFFF_FFFF) begin n_bad++; $display("FAIL sat_sum: got %h exp ffffffffff", bus2.energy_sum); end
    n_vec++; if (bus2.second_value !== 38'h3F_FFFF_FFFF || bus2.peak_shift !== 15'd0) begin n_bad++; $display("FAIL sat_values: second=%h shift=%0d exp 3fffffffff/0", bus2.second_value, bus2.peak_shift); end
    n_vec++; if (bus2.detected !== 1'b0) begin n_bad++; $display("FAIL sat_detected: got %0b exp 0", bus2.detected); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.num_shifts = '0; bus.threshold = '0;
    bus.i2q2 = '0; bus.i2q2_valid = 1'b0; bus.code_shift = '0;
    bus2.start = 1'b0; bus2.num_shifts = '0; bus2.threshold = '0;
    bus2.i2q2 = '0; bus2.i2q2_valid = 1'b0; bus2.code_shift = '0;
    test_reset();
    test_basic_detect();
    test_margin_fail();
    test_ties();
    test_threshold();
    test_zero_shifts();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/acq_peak_search.md
Name: acq_peak_search

Overview:
- Downstream consumer of the subchannel correlator's `i2q2`/`i2q2_valid` stream.
- Over one acquisition sweep of `num_shifts` code-shift results, tracks the largest and second-largest I²+Q² values, the code shift of the largest, and the running energy sum.
- At sweep end, issues a detect decision: absolute threshold plus peak-to-second margin.
- Sits between the correlator top and the display/readout logic on the 200 MHz domain.

Parameters:
- I2Q2_WIDTH, 38, width of incoming i2q2 magnitude words.
- SHIFT_WIDTH, 15, width of code shift index and of shift count.
- MARGIN_SHIFT, 2, required margin: peak must exceed second + (second >> MARGIN_SHIFT).
- SUM_WIDTH, 53, width of energy accumulator (I2Q2_WIDTH+SHIFT_WIDTH).

Ports:
- clk  in  1  correlator clock (200 MHz)
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a sweep
- num_shifts  in  SHIFT_WIDTH  results expected in this sweep, sampled at start
- threshold  in  I2Q2_WIDTH  absolute detection threshold, sampled at start
- i2q2  in  I2Q2_WIDTH  correlation magnitude from correlator
- i2q2_valid  in  1  one-cycle strobe qualifying i2q2/code_shift
- code_shift  in  SHIFT_WIDTH  code shift associated with i2q2
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at sweep completion
- detected  out  1  decision, valid from done until next start
- peak_value  out  I2Q2_WIDTH  largest i2q2 of sweep
- peak_shift  out  SHIFT_WIDTH  code_shift of largest
- second_value  out  I2Q2_WIDTH  second-largest i2q2 of sweep
- energy_sum  out  SUM_WIDTH  saturating sum of all i2q2 in sweep
- result_count  out  SHIFT_WIDTH  valid results absorbed so far

Behaviour:
- Reset: state IDLE; all outputs 0; latched num_shifts/threshold 0.
- State IDLE:
  - i2q2_valid ignored.
  - start → latch num_shifts/threshold, clear peak/second/sum/count/detected, go SEARCH (busy=1 next cycle).
  - If latched num_shifts==0, go FINISH instead.
- State SEARCH, on each i2q2_valid:
  - result_count += 1.
  - energy_sum += i2q2, saturating at all-ones.
  - If i2q2 > peak_value: second_value ← peak_value; peak_value ← i2q2; peak_shift ← code_shift.
  - Else if i2q2 > second_value: second_value ← i2q2.
  - Ties are strict: first occurrence wins; an equal value does not move the peak, but may fill second if second is smaller.
  - Valid absorbing the num_shifts-th result → FINISH on same edge.
- State FINISH (one cycle):
  - detected ← (peak_value >= threshold) && (peak_value > second_value + (second_value >> MARGIN_SHIFT)).
  - The margin sum is computed in I2Q2_WIDTH+1 bits; no wrap.
  - done=1 for exactly this one registered cycle, busy ← 0, return to IDLE.
- Latency: done is visible in the cycle after the edge sampling the final valid.
- After done: results hold stable until the next accepted start.
- Boundary cases:
  - start while busy: ignored; sweep continues unaffected.
  - start coincident with i2q2_valid in IDLE: that valid is not counted.
  - i2q2_valid in FINISH: ignored.
  - num_shifts==0: done one cycle after start+1; detected=0, all values 0.
  - result_count never exceeds num_shifts; extra valids after completion are ignored.
  - reset mid-sweep: immediate return to IDLE with all outputs cleared; no done pulse.
  - Back-to-back valids every cycle: supported; no backpressure, no drops.

Test Plan:
- Reset, start num_shifts=4, threshold=100, i2q2=10,300,50,20 at shifts 0..3 → done once; peak_value=300, peak_shift=1, second_value=50, energy_sum=380, detected=1.
- num_shifts=3, values 200,190,5, threshold=100 → margin fails (190+47=237 ≥ 200); detected=0, peak_shift=0, second_value=190.
- num_shifts=3, values 80,80,80 every cycle → peak_value=80, peak_shift=first shift, second_value=80, detected=0 (threshold 50, margin fails).
- num_shifts=0 start → done exactly two cycles after the start edge, detected=0, result_count=0; a second start while busy in a long sweep leaves result_count and peak untouched.
- Saturation: energy_sum preloaded near max via many valids of all-ones i2q2 → energy_sum sticks at all-ones, no wrap.
- reset asserted after 2 of 5 results → all outputs 0 next cycle, no done; a new start then runs a clean sweep.
